// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// requester port indices, used by mem_arbiter and its round-robin picker.
// Latency: none (types/constants only). Backpressure: not applicable.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: chooses which requester to grant next.
// Latency: purely combinational. Backpressure: none; the caller samples it only when idle.
// Ports: req[1:0] (bit index = port), last_gnt (port served last), valid (any request), winner (port index).
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (req == 2'b11) begin
            // Contention: hand the grant to whoever was not served last.
            winner = ~last_gnt;
        end else if (req[PORT_LDR]) begin
            winner = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU (port 0) and the UART loader (port 1).
// Latency: write acks in the cycle after the request is sampled; read acks 2+RD_LAT cycles after.
// Backpressure: requests are held until ack; a request arriving while busy waits for the next IDLE.
// Ports: clk/reset; cpu_* and ldr_* request/ack/rdata per port; mem_* macro interface; busy.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1    // legal range 1..3 (wait_cnt is 2 bits)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t  state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_gnt, last_gnt_nxt;
    logic [1:0]  wait_cnt, wait_cnt_nxt;
    logic        done;      // owner's ack this cycle
    logic        capture;   // load owner's rdata register at this edge
    logic        pick_valid;
    logic        pick_winner;

    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    rr_pick2 u_pick (
        .req      ({ldr_req, cpu_req}),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    // Owner's live inputs; requesters keep them stable for the whole transaction.
    assign own_we    = (owner == PORT_LDR) ? ldr_we    : cpu_we;
    assign own_addr  = (owner == PORT_LDR) ? ldr_addr  : cpu_addr;
    assign own_wdata = (owner == PORT_LDR) ? ldr_wdata : cpu_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= PORT_CPU;
            last_gnt <= PORT_LDR;   // CPU wins the first tie
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        wait_cnt_nxt = wait_cnt;
        done         = 1'b0;
        capture      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_nxt = pick_winner;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (own_we) begin
                    // Writes complete with the strobe itself; no read wait needed.
                    done         = 1'b1;
                    last_gnt_nxt = owner;
                    state_nxt    = ARB_IDLE;
                end else begin
                    wait_cnt_nxt = 2'(RD_LAT - 1);
                    state_nxt    = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = ARB_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                end
            end
            ARB_RESP: begin
                done         = 1'b1;
                last_gnt_nxt = owner;
                state_nxt    = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Read data registers: only the owner's register is ever written, and
    // the completion does not depend on req still being high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else if (capture) begin
            if (owner == PORT_LDR) ldr_rdata <= mem_rdata;
            else                   cpu_rdata <= mem_rdata;
        end
    end

    assign cpu_ack = done && (owner == PORT_CPU);
    assign ldr_ack = done && (owner == PORT_LDR);
    assign mem_en  = (state == ARB_ISSUE);
    assign mem_we  = mem_en && own_we;
    assign busy    = (state != ARB_IDLE);

    // Address/data are a live mux of the owner's inputs; forced to zero while
    // reset is held so the macro sees a quiet bus.
    assign mem_addr  = reset ? '0 : own_addr;
    assign mem_wdata = reset ? '0 : own_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses RD_LAT=1, instance b RD_LAT=3,
// each backed by a small behavioural memory with the matching read latency.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- instance a (RD_LAT = 1) ----------------
    logic        a_cpu_req = 0, a_cpu_we = 0, a_ldr_req = 0, a_ldr_we = 0;
    logic [9:0]  a_cpu_addr = 0, a_ldr_addr = 0;
    logic [31:0] a_cpu_wdata = 0, a_ldr_wdata = 0;
    logic        a_cpu_ack, a_ldr_ack, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_cpu_rdata, a_ldr_rdata, a_mem_wdata, a_mem_rdata;
    logic [9:0]  a_mem_addr;

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata),
        .ldr_ack(a_ldr_ack), .ldr_rdata(a_ldr_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    logic [31:0] mem_a [0:1023];
    logic [31:0] a_p0;
    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        if (a_mem_en) a_p0 <= mem_a[a_mem_addr];
    end
    assign a_mem_rdata = a_p0;

    // ---------------- instance b (RD_LAT = 3) ----------------
    logic        b_cpu_req = 0, b_cpu_we = 0, b_ldr_req = 0, b_ldr_we = 0;
    logic [9:0]  b_cpu_addr = 0, b_ldr_addr = 0;
    logic [31:0] b_cpu_wdata = 0, b_ldr_wdata = 0;
    logic        b_cpu_ack, b_ldr_ack, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_cpu_rdata, b_ldr_rdata, b_mem_wdata, b_mem_rdata;
    logic [9:0]  b_mem_addr;

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
        .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    logic [31:0] mem_b [0:1023];
    logic [31:0] b_p0, b_p1, b_p2;
    always @(posedge clk) begin
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        if (b_mem_en) b_p0 <= mem_b[b_mem_addr];
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_mem_rdata = b_p2;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call just after the edge that opens cycle 0 with the request(s) driven.
    // Returns at the negedge of the ack cycle (or after a 20-cycle budget, ack_cyc = -1).
    task automatic run_txn(input bit sel, output int ack_cyc, output bit ack_port,
                           output bit both_ack, output int en_cnt, output int en_cyc,
                           output logic [9:0] en_addr, output logic en_we,
                           output logic [31:0] en_wdata);
        logic ca, la, me;
        ack_cyc = -1; ack_port = 0; both_ack = 0;
        en_cnt = 0; en_cyc = -1; en_addr = '0; en_we = 0; en_wdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ca = sel ? b_cpu_ack : a_cpu_ack;
            la = sel ? b_ldr_ack : a_ldr_ack;
            me = sel ? b_mem_en  : a_mem_en;
            if (me) begin
                en_cnt++;
                if (en_cyc < 0) begin
                    en_cyc   = i;
                    en_addr  = sel ? b_mem_addr  : a_mem_addr;
                    en_we    = sel ? b_mem_we    : a_mem_we;
                    en_wdata = sel ? b_mem_wdata : a_mem_wdata;
                end
            end
            if (ca || la) begin
                ack_cyc  = i;
                ack_port = la;
                both_ack = ca && la;
                break;
            end
            step();
        end
    endtask

    int          ack_cyc, en_cnt, en_cyc;
    bit          ack_port, both_ack;
    logic [9:0]  en_addr;
    logic        en_we;
    logic [31:0] en_wdata;

    initial begin
        // ---- reset values (asynchronous) ----
        a_cpu_addr = 10'h123; a_cpu_wdata = 32'h55AA55AA;
        #1 reset = 1'b1;
        #2;
        chk("rst_busy",     a_busy, 0);
        chk("rst_acks",     {a_cpu_ack, a_ldr_ack}, 0);
        chk("rst_mem_en",   {a_mem_en, a_mem_we}, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_mem_wd",   a_mem_wdata, 0);
        chk("rst_rdata",    {a_cpu_rdata, a_ldr_rdata}, 0);
        chk("rst_b_busy",   b_busy, 0);
        @(negedge clk) reset = 1'b0;

        // ---- preload via loader writes: 0x030=C0DE, 0x040=1DE5 ----
        step();
        a_ldr_req = 1; a_ldr_we = 1; a_ldr_addr = 10'h030; a_ldr_wdata = 32'h0000C0DE;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("pre1_ack_cyc", ack_cyc, 1);
        step();
        a_ldr_addr = 10'h040; a_ldr_wdata = 32'h00001DE5;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("pre2_ack_cyc", ack_cyc, 1);
        step();
        a_ldr_req = 0; a_ldr_we = 0;
        // re-reset so last_gnt starts at the loader again
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // ---- tie after reset: CPU first, then loader ----
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 10'h030;
        a_ldr_req = 1; a_ldr_we = 0; a_ldr_addr = 10'h040;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("tie1_cyc",   ack_cyc, 3);
        chk("tie1_port",  {both_ack, ack_port}, 2'b00);
        chk("tie1_addr",  en_addr, 10'h030);
        chk("tie1_rdata", a_cpu_rdata, 32'h0000C0DE);
        chk("tie1_ldr_rdata", a_ldr_rdata, 0);
        step();
        a_cpu_req = 0;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("tie2_cyc",   ack_cyc, 3);
        chk("tie2_port",  {both_ack, ack_port}, 2'b01);
        chk("tie2_addr",  en_addr, 10'h040);
        chk("tie2_rdata", a_ldr_rdata, 32'h00001DE5);
        chk("tie2_cpu_rdata", a_cpu_rdata, 32'h0000C0DE);
        step();
        a_ldr_req = 0;

        // ---- single CPU write then read ----
        a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 10'h010; a_cpu_wdata = 32'hDEADBEEF;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("wr_ack_cyc", ack_cyc, 1);
        chk("wr_port",    {both_ack, ack_port}, 2'b00);
        chk("wr_en_cyc",  en_cyc, 1);
        chk("wr_we",      en_we, 1);
        chk("wr_addr",    en_addr, 10'h010);
        chk("wr_wdata",   en_wdata, 32'hDEADBEEF);
        step();
        chk("wr_idle_after", a_busy, 0);
        a_cpu_we = 0;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("rd_ack_cyc", ack_cyc, 3);
        chk("rd_en_cnt",  en_cnt, 1);
        chk("rd_we",      en_we, 0);
        chk("rd_rdata",   a_cpu_rdata, 32'hDEADBEEF);
        step();

        // ---- continuous contention: 8 transactions, loader first (CPU served last) ----
        a_ldr_req = 1; a_ldr_we = 0; a_ldr_addr = 10'h040;
        for (int k = 0; k < 8; k++) begin
            run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
            chk($sformatf("cont%0d_port", k), {both_ack, ack_port}, {1'b0, (k % 2 == 0)});
            chk($sformatf("cont%0d_cyc", k), ack_cyc, 3);
            if (k % 2 == 1) chk($sformatf("cont%0d_ldr_hold", k), a_ldr_rdata, 32'h00001DE5);
            else            chk($sformatf("cont%0d_cpu_hold", k), a_cpu_rdata, 32'hDEADBEEF);
            step();
        end
        a_cpu_req = 0; a_ldr_req = 0;

        // ---- reset mid-read: ldr_rdata = A5A5A5A5 first ----
        a_ldr_req = 1; a_ldr_we = 1; a_ldr_addr = 10'h050; a_ldr_wdata = 32'hA5A5A5A5;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("a5_wr_cyc", ack_cyc, 1);
        step();
        a_ldr_we = 0;
        run_txn(0, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("a5_rd_rdata", a_ldr_rdata, 32'hA5A5A5A5);
        step();
        a_ldr_addr = 10'h010;            // cycle 0 (IDLE, request held)
        step();                          // cycle 1 ISSUE
        step();                          // cycle 2 WAIT
        chk("mid_busy_wait", a_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy",  a_busy, 0);
        chk("mid_rst_ack",   a_ldr_ack, 0);
        chk("mid_rst_rdata", a_ldr_rdata, 0);
        chk("mid_rst_mem",   {a_mem_en, a_mem_we}, 0);
        @(posedge clk);
        a_ldr_req = 0;
        @(negedge clk);
        chk("mid_rst_hold_ack", a_ldr_ack, 0);
        chk("mid_rst_hold_rd",  a_ldr_rdata, 0);
        reset = 1'b0;
        step();

        // ---- protocol violation: CPU drops req in WAIT ----
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 10'h040;   // cycle 0
        step();                                              // cycle 1 ISSUE
        step();                                              // cycle 2 WAIT
        a_cpu_req = 0;
        @(negedge clk);
        chk("viol_wait_busy", a_busy, 1);
        step();                                              // cycle 3 RESP
        @(negedge clk);
        chk("viol_ack",   a_cpu_ack, 1);
        chk("viol_rdata", a_cpu_rdata, 32'h00001DE5);
        step();
        @(negedge clk);
        chk("viol_idle", a_busy, 0);
        step();

        // ---- RD_LAT = 3, wrap-edge address 0x3FF ----
        b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 10'h3FF; b_cpu_wdata = 32'hFEEDF00D;
        run_txn(1, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("lat3_wr_cyc", ack_cyc, 1);
        step();
        b_cpu_we = 0;
        run_txn(1, ack_cyc, ack_port, both_ack, en_cnt, en_cyc, en_addr, en_we, en_wdata);
        chk("lat3_ack_cyc", ack_cyc, 5);
        chk("lat3_en_cnt",  en_cnt, 1);
        chk("lat3_en_cyc",  en_cyc, 1);
        chk("lat3_addr",    en_addr, 10'h3FF);
        chk("lat3_rdata",   b_cpu_rdata, 32'hFEEDF00D);
        step();
        b_cpu_req = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port transaction arbiter that shares the single-port unified instruction/data memory between the multicycle CPU (port 0) and the UART program loader (port 1). Each requester presents a held request and gets one acknowledge pulse per transaction. The arbiter sequences the memory enable, write strobe and read-latency wait, and alternates grants round-robin under contention. It sits between the CPU memory mux (PC/ALUOut address select) and the memory macro.

## Interface
- `ADDR_W`, default 10: memory word-address width.
- `DATA_W`, default 32: data width.
- `RD_LAT`, default 1: memory read latency in cycles; legal range 1..3.

- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `cpu_req` input 1: CPU transaction request; held until `cpu_ack`.
- `cpu_we` input 1: 1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr` input ADDR_W: word address; stable while `cpu_req`.
- `cpu_wdata` input DATA_W: write data; stable while `cpu_req`.
- `cpu_ack` output 1: one-cycle completion pulse.
- `cpu_rdata` output DATA_W: registered read data; valid with `cpu_ack` on reads; held until the next CPU read completes.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rdata`: same widths and semantics for the loader port.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: memory write strobe; only asserted with `mem_en`.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_rdata` input DATA_W: memory read data, valid `RD_LAT` cycles after the `mem_en` read cycle.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If no request, stay in IDLE.
  - If exactly one port requests, grant it.
  - If both request, grant the port that is not `last_gnt`.
  - Latch the winner into `owner` and go to ISSUE.
- **ISSUE**
  - `mem_en` = 1; `mem_we` = owner's `we`.
  - `mem_addr` and `mem_wdata` are muxed from the owner's live inputs.
  - Write: assert the owner's ack this cycle, set `last_gnt` = owner, go to IDLE.
  - Read: load `wait_cnt` = `RD_LAT`-1 and go to WAIT.
- **WAIT**
  - `mem_en` = 0.
  - If `wait_cnt` = 0: capture `mem_rdata` into the owner's rdata register and go to RESP.
  - Otherwise decrement `wait_cnt`.
- **RESP**: assert the owner's ack, set `last_gnt` = owner, go to IDLE.
- The non-owner's ack is never asserted, and its rdata never changes.
- A request still high in the IDLE cycle after its ack starts a new transaction. A requester must drop `req` on the edge where it samples ack if it wants no further transaction.
- A requester dropping `req` mid-transaction is a protocol violation. The transaction completes anyway: the write is performed, or the read data is captured and ack issued.
- Outside ISSUE, `mem_en` and `mem_we` are 0. `mem_addr` and `mem_wdata` follow the owner's inputs (don't-care to memory).

## Timing
- **Reset values**:
  - State = IDLE; `owner` = 0.
  - `last_gnt` = 1 (loader), so the CPU wins the first tie.
  - `wait_cnt` = 0.
  - All acks, `mem_en`, `mem_we` and `busy` = 0.
  - `cpu_rdata`, `ldr_rdata`, `mem_addr` and `mem_wdata` = 0.
- Reset asserted mid-transaction aborts it immediately: no ack, no rdata update. An in-flight memory write already strobed stands.
- **Write latency**: `req` sampled in IDLE at cycle 0; `mem_en`/`mem_we` and ack in cycle 1. Two cycles per write, back to back.
- **Read latency**: IDLE cycle 0, ISSUE cycle 1, WAIT cycles 2..1+`RD_LAT`, ack with valid rdata in cycle 2+`RD_LAT`. With `RD_LAT`=1, ack comes in cycle 3.
- A request arriving while `busy` waits; it is evaluated on the next IDLE cycle.
- Simultaneous requests alternate strictly, so neither port waits more than one transaction.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encoding `ARB_IDLE`=2'b00, `ARB_ISSUE`=2'b01, `ARB_WAIT`=2'b10, `ARB_RESP`=2'b11;
  - port indices `PORT_CPU`=0, `PORT_LDR`=1.
- One sub-module: `rr_pick2`, a combinational two-way round-robin picker. Inputs are `req[1:0]` and `last_gnt`; outputs are `valid` and `winner`.
- FSM, counter, muxes and rdata registers live in `mem_arbiter`.

## Test plan
- **Reset**: assert `reset` mid-read in WAIT, with `ldr_rdata` previously 0xA5A5A5A5. Required: outputs return to reset values asynchronously, no `ldr_ack` is issued, and `ldr_rdata` reads 0.
- **Single CPU write, then read**:
  - CPU writes 0xDEADBEEF to address 0x010: `mem_en`=`mem_we`=1 with `mem_addr`=0x010 in cycle 1, `cpu_ack` in cycle 1.
  - CPU reads 0x010 with `RD_LAT`=1: `cpu_ack` in cycle 3 with `cpu_rdata`=0xDEADBEEF.
- **Tie after reset**: both ports request reads simultaneously. Required: CPU is served first, then the loader; ack order cpu, ldr; no ack for a port it does not own.
- **Continuous contention**: both hold requests for 8 transactions. Required: grants strictly alternate and `ldr_rdata` never changes during CPU acks.
- **`RD_LAT`=3**: read address 0x3FF (wrap-edge address). Required: ack exactly at cycle 5, and `mem_en` high only in cycle 1.
- **Protocol violation**: CPU drops `req` in the WAIT cycle. Required: `cpu_ack` still pulses in RESP and `cpu_rdata` updates.
